serial_operand_transmitter: RTL and testbench



---
 rtl/serial_operand_transmitter.sv | 140 ++++++++++++++
 tb/tb_serial_operand_transmitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_transmitter.sv
// Serialises a pair of operands LSB-first onto two lines as frames of DATA_W data bits plus one
// dummy zero bit, with optional continuous retransmission of the held pair.
module serial_operand_transmitter #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              repeat_en,
  output logic              tx_bit_1,
  output logic              tx_bit_2,
  output logic              frame_start,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  // Last data-bit index; the remaining frame cycle is the dummy bit.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 2);

  typedef enum logic [1:0] {StIdle, StShift, StGuard} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] hold_1_q, hold_1_d;
  logic [DATA_W-1:0] hold_2_q, hold_2_d;
  logic [DATA_W-1:0] shift_1_q, shift_1_d;
  logic [DATA_W-1:0] shift_2_q, shift_2_d;
  logic              tx_1_q, tx_1_d;
  logic              tx_2_q, tx_2_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  frames_sent_q, frames_sent_d;
  logic              ready_en_q;

  logic              accept;
  logic              load;
  logic [DATA_W-1:0] src_1;
  logic [DATA_W-1:0] src_2;

  // State and datapath registers; reset is active-high and asynchronous.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      hold_1_q      <= '0;
      hold_2_q      <= '0;
      shift_1_q     <= '0;
      shift_2_q     <= '0;
      tx_1_q        <= 1'b0;
      tx_2_q        <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frames_sent_q <= '0;
      ready_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hold_1_q      <= hold_1_d;
      hold_2_q      <= hold_2_d;
      shift_1_q     <= shift_1_d;
      shift_2_q     <= shift_2_d;
      tx_1_q        <= tx_1_d;
      tx_2_q        <= tx_2_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      frames_sent_q <= frames_sent_d;
      ready_en_q    <= 1'b1;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (idx_q == LAST_IDX) state_d = StGuard;
      StGuard: state_d = (accept || repeat_en) ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A new frame starts from IDLE on accept, or from GUARD on accept or repeat.
  assign load  = ((state_q == StIdle) && accept) ||
                 ((state_q == StGuard) && (accept || repeat_en));
  assign src_1 = accept ? operand_1 : hold_1_q;
  assign src_2 = accept ? operand_2 : hold_2_q;

  always_comb begin
    in_ready      = ready_en_q && ((state_q == StIdle) || (state_q == StGuard));
    idx_d         = idx_q;
    hold_1_d      = hold_1_q;
    hold_2_d      = hold_2_q;
    shift_1_d     = shift_1_q;
    shift_2_d     = shift_2_q;
    tx_1_d        = 1'b0;
    tx_2_d        = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    frames_sent_d = frames_sent_q;

    if (state_q == StGuard) begin
      frames_sent_d = frames_sent_q + 1'b1;
    end

    if (load) begin
      hold_1_d      = src_1;
      hold_2_d      = src_2;
      shift_1_d     = {1'b0, src_1[DATA_W-1:1]};
      shift_2_d     = {1'b0, src_2[DATA_W-1:1]};
      tx_1_d        = src_1[0];
      tx_2_d        = src_2[0];
      idx_d         = '0;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
    end else if (state_q == StShift) begin
      busy_d = 1'b1;
      if (idx_q != LAST_IDX) begin
        tx_1_d    = shift_1_q[0];
        tx_2_d    = shift_2_q[0];
        shift_1_d = {1'b0, shift_1_q[DATA_W-1:1]};
        shift_2_d = {1'b0, shift_2_q[DATA_W-1:1]};
        idx_d     = idx_q + 1'b1;
      end
    end
  end

  assign tx_bit_1    = tx_1_q;
  assign tx_bit_2    = tx_2_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Directed bench for serial_operand_transmitter: frame contents, back-to-back, repeat,
// ignored input, mid-frame reset and counter wrap.
module tb_serial_operand_transmitter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] operand_1;
  logic [8:0] operand_2;
  logic       repeat_en;
  logic       tx_bit_1;
  logic       tx_bit_2;
  logic       frame_start;
  logic       busy;
  logic [7:0] frames_sent;

  int n_vec;
  int n_bad;

  serial_operand_transmitter #(
    .DATA_W (9),
    .FRAME_W(10),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .repeat_en  (repeat_en),
    .tx_bit_1   (tx_bit_1),
    .tx_bit_2   (tx_bit_2),
    .frame_start(frame_start),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    repeat_en = 1'b0;
    operand_1 = '0;
    operand_2 = '0;
    #2;
    check("rst_tx1", 32'(tx_bit_1), 32'd0);
    check("rst_tx2", 32'(tx_bit_2), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_cnt", 32'(frames_sent), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);
  endtask

  // Observes one 10-cycle frame starting right after the accepting edge.
  // hold_v keeps in_valid high through SHIFT; at the GUARD cycle in_valid becomes g_v with
  // operands n1/n2. poke_k >= 0 pulses in_valid with operand_1=0 mid-SHIFT. repeat_en is set
  // to rep_after at k==5.
  task automatic run_frame(input string tag, input logic [8:0] e1, input logic [8:0] e2,
                           input bit hold_v, input bit g_v, input logic [8:0] n1,
                           input logic [8:0] n2, input int poke_k, input bit rep_after);
    for (int k = 0; k < 10; k++) begin
      check({tag, "_tx1"}, 32'(tx_bit_1), (k < 9) ? 32'(e1[k]) : 32'd0);
      check({tag, "_tx2"}, 32'(tx_bit_2), (k < 9) ? 32'(e2[k]) : 32'd0);
      check({tag, "_fs"}, 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_rdy"}, 32'(in_ready), (k == 9) ? 32'd1 : 32'd0);
      if (k == 0 && !hold_v) in_valid = 1'b0;
      if (k == poke_k) begin
        in_valid  = 1'b1;
        operand_1 = 9'h000;
      end
      if (poke_k >= 0 && k == poke_k + 1) in_valid = 1'b0;
      if (k == 5) repeat_en = rep_after;
      if (k == 9) begin
        in_valid  = g_v;
        operand_1 = n1;
        operand_2 = n2;
      end
      tick();
    end
  endtask

  task automatic accept_pair(input logic [8:0] a, input logic [8:0] b);
    operand_1 = a;
    operand_2 = b;
    in_valid  = 1'b1;
    tick();
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    repeat_en = 1'b0;
    operand_1 = '0;
    operand_2 = '0;

    // Single frame
    do_reset();
    check("idle_busy", 32'(busy), 32'd0);
    accept_pair(9'h1A5, 9'h0F0);
    run_frame("single", 9'h1A5, 9'h0F0, 1'b0, 1'b0, 9'h0, 9'h0, -1, 1'b0);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_cnt", 32'(frames_sent), 32'd1);
    check("single_rdy_end", 32'(in_ready), 32'd1);
    check("single_tx1_end", 32'(tx_bit_1), 32'd0);

    // Back-to-back
    do_reset();
    accept_pair(9'h1FF, 9'h000);
    run_frame("b2b_a", 9'h1FF, 9'h000, 1'b1, 1'b1, 9'h001, 9'h100, -1, 1'b0);
    run_frame("b2b_b", 9'h001, 9'h100, 1'b0, 1'b0, 9'h0, 9'h0, -1, 1'b0);
    check("b2b_busy_end", 32'(busy), 32'd0);
    check("b2b_cnt", 32'(frames_sent), 32'd2);

    // Repeat mode
    do_reset();
    repeat_en = 1'b1;
    accept_pair(9'h0AA, 9'h155);
    run_frame("rep1", 9'h0AA, 9'h155, 1'b0, 1'b0, 9'h0AA, 9'h155, -1, 1'b1);
    run_frame("rep2", 9'h0AA, 9'h155, 1'b0, 1'b0, 9'h0AA, 9'h155, -1, 1'b1);
    run_frame("rep3", 9'h0AA, 9'h155, 1'b0, 1'b0, 9'h0AA, 9'h155, -1, 1'b0);
    check("rep_busy_end", 32'(busy), 32'd0);
    check("rep_cnt", 32'(frames_sent), 32'd3);

    // Ignored input mid-SHIFT
    do_reset();
    accept_pair(9'h1A5, 9'h0F0);
    run_frame("ign", 9'h1A5, 9'h0F0, 1'b0, 1'b0, 9'h0, 9'h0F0, 3, 1'b0);
    check("ign_busy_end", 32'(busy), 32'd0);
    tick();
    check("ign_no_extra", 32'(busy), 32'd0);
    check("ign_cnt", 32'(frames_sent), 32'd1);

    // Reset mid-frame at bit index 4
    do_reset();
    accept_pair(9'h1FF, 9'h1FF);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("mid_pre_busy", 32'(busy), 32'd1);
    check("mid_pre_tx1", 32'(tx_bit_1), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_tx1", 32'(tx_bit_1), 32'd0);
    check("mid_tx2", 32'(tx_bit_2), 32'd0);
    check("mid_fs", 32'(frame_start), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_cnt", 32'(frames_sent), 32'd0);
    #1;
    rst_n = 1'b0;
    tick();
    check("mid_rdy", 32'(in_ready), 32'd1);
    accept_pair(9'h1A5, 9'h0F0);
    run_frame("mid_new", 9'h1A5, 9'h0F0, 1'b0, 1'b0, 9'h0, 9'h0, -1, 1'b0);
    check("mid_new_cnt", 32'(frames_sent), 32'd1);

    // Counter wrap over 256 repeated frames
    do_reset();
    repeat_en = 1'b1;
    accept_pair(9'h0AA, 9'h155);
    in_valid = 1'b0;
    for (int k = 0; k < 2550; k++) tick();
    check("wrap_255", 32'(frames_sent), 32'd255);
    for (int k = 0; k < 10; k++) tick();
    check("wrap_0", 32'(frames_sent), 32'd0);
    run_frame("wrap_257", 9'h0AA, 9'h155, 1'b0, 1'b0, 9'h0AA, 9'h155, -1, 1'b0);
    check("wrap_end_cnt", 32'(frames_sent), 32'd1);
    check("wrap_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
